// File: rtl/ce_window_gen_if.sv
// Pixel-stream in / window-stream out bundle for ce_window_gen.
// Handshake: pix_valid qualifies pix_in/pix_sof in the same cycle, and there is no ready (no backpressure);
// en_out qualifies data2conv for exactly one cycle per window, and CE_net must accept it in that cycle.
interface ce_window_gen_if #(
  parameter int CL_IN  = 5,
  parameter int KERNEL = 3,
  parameter int N      = 4
);
  logic [CL_IN*N-1:0]               pix_in;
  logic                             pix_valid;
  logic                             pix_sof;
  logic [CL_IN*KERNEL*KERNEL*N-1:0] data2conv;
  logic                             en_out;
  logic                             frame_done;

  modport master (
    output pix_in, pix_valid, pix_sof,
    input  data2conv, en_out, frame_done
  );

  modport slave (
    input  pix_in, pix_valid, pix_sof,
    output data2conv, en_out, frame_done
  );
endinterface

// File: rtl/ce_window_gen.sv
// Raster pixel stream to KERNELxKERNEL "valid" convolution windows for CE_net.
// Line buffers hold KERNEL-1 previous rows, and a column shift register forms the window.
module ce_window_gen #(
  parameter int CL_IN  = 5,
  parameter int KERNEL = 3,
  parameter int N      = 4,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input logic           clk,
  input logic           rst,
  ce_window_gen_if.slave bus
);
  localparam int PW = CL_IN * N;
  localparam int WW = CL_IN * KERNEL * KERNEL * N;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [CW-1:0] col;
  logic [CW-1:0] eff_col;
  logic [RW-1:0] row;
  logic [RW-1:0] eff_row;
  logic          accept;
  logic          win_valid;
  logic          last_pix;

  logic [PW-1:0] new_col  [KERNEL];
  logic [PW-1:0] win      [KERNEL][KERNEL];
  logic [PW-1:0] win_next [KERNEL][KERNEL];
  logic [WW-1:0] packed_next;

  logic [WW-1:0] data_q;
  logic          en_q;
  logic          done_q;

  // A start-of-frame pixel is always (0,0), whatever the counters say.
  always_comb begin
    accept    = bus.pix_valid;
    eff_col   = bus.pix_sof ? '0 : col;
    eff_row   = bus.pix_sof ? '0 : row;
    win_valid = (int'(eff_row) >= KERNEL - 1) && (int'(eff_col) >= KERNEL - 1);
    last_pix  = (int'(eff_col) == IMG_W - 1) && (int'(eff_row) == IMG_H - 1);
  end

  generate
    if (KERNEL > 1) begin : g_lb
      logic [PW-1:0] lb [KERNEL-1][IMG_W];

      // lb[0] holds the previous row and lb[KERNEL-2] the oldest row. The contents are never reset.
      always_ff @(posedge clk) begin
        if (accept) begin
          lb[0][eff_col] <= bus.pix_in;
          for (int j = 1; j < KERNEL - 1; j++) begin
            lb[j][eff_col] <= lb[j-1][eff_col];
          end
        end
      end

      always_comb begin
        for (int r = 0; r < KERNEL - 1; r++) begin
          new_col[r] = lb[KERNEL-2-r][eff_col];
        end
        new_col[KERNEL-1] = bus.pix_in;
      end
    end else begin : g_nolb
      assign new_col[0] = bus.pix_in;
    end
  endgenerate

  // Shift the window left by one column. The new column enters at k = KERNEL-1, the rightmost column.
  always_comb begin
    for (int r = 0; r < KERNEL; r++) begin
      for (int k = 0; k < KERNEL - 1; k++) begin
        win_next[r][k] = win[r][k+1];
      end
      win_next[r][KERNEL-1] = new_col[r];
    end
  end

  always_comb begin
    packed_next = '0;
    for (int c = 0; c < CL_IN; c++) begin
      for (int r = 0; r < KERNEL; r++) begin
        for (int k = 0; k < KERNEL; k++) begin
          packed_next[((c*KERNEL + r)*KERNEL + k)*N +: N] = win_next[r][k][c*N +: N];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col    <= '0;
      row    <= '0;
      data_q <= '0;
      en_q   <= 1'b0;
      done_q <= 1'b0;
      for (int r = 0; r < KERNEL; r++) begin
        for (int k = 0; k < KERNEL; k++) begin
          win[r][k] <= '0;
        end
      end
    end else begin
      en_q   <= accept && win_valid;
      done_q <= accept && last_pix;
      if (accept) begin
        if (int'(eff_col) == IMG_W - 1) begin
          col <= '0;
          row <= (int'(eff_row) == IMG_H - 1) ? '0 : eff_row + 1'b1;
        end else begin
          col <= eff_col + 1'b1;
          row <= eff_row;
        end
        win <= win_next;
        // Windows that straddle a row wrap are never loaded, so data2conv keeps the last real window.
        if (win_valid) begin
          data_q <= packed_next;
        end
      end
    end
  end

  assign bus.data2conv  = data_q;
  assign bus.en_out     = en_q;
  assign bus.frame_done = done_q;
endmodule

// File: tb/tb_ce_window_gen.sv
// Self-checking bench for ce_window_gen with two instances: 1ch K=3 5x5 and 2ch K=1 3x3.
// A 2D image model builds every expected window and queues it when the pixel is driven.
module tb_ce_window_gen;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ce_window_gen_if #(.CL_IN(1), .KERNEL(3), .N(4)) a_if ();
  ce_window_gen_if #(.CL_IN(2), .KERNEL(1), .N(4)) b_if ();

  ce_window_gen #(.CL_IN(1), .KERNEL(3), .N(4), .IMG_W(5), .IMG_H(5)) dut_a (
    .clk(clk), .rst(rst), .bus(a_if)
  );
  ce_window_gen #(.CL_IN(2), .KERNEL(1), .N(4), .IMG_W(3), .IMG_H(3)) dut_b (
    .clk(clk), .rst(rst), .bus(b_if)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [36:0] exp_q_a[$];
  logic [8:0]  exp_q_b[$];
  logic [3:0]  img_a [5][5];
  int ra = 0, ca = 0, rb = 0, cb = 0;
  int got_a = 0, done_a = 0, got_b = 0, done_b = 0;
  logic [35:0] last_a;
  logic [7:0]  last_b;
  logic acc_a, acc_b;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_a(input logic [3:0] px, input logic sof);
    logic [35:0] w;
    @(posedge clk); #1;
    a_if.pix_in = px; a_if.pix_valid = 1'b1; a_if.pix_sof = sof;
    if (sof) begin ra = 0; ca = 0; end
    img_a[ra][ca] = px;
    if (ra >= 2 && ca >= 2) begin
      w = '0;
      for (int r = 0; r < 3; r++)
        for (int k = 0; k < 3; k++)
          w[(r*3 + k)*4 +: 4] = img_a[ra-2+r][ca-2+k];
      exp_q_a.push_back({(ra == 4 && ca == 4), w});
    end
    if (ca == 4) begin ca = 0; ra = (ra == 4) ? 0 : ra + 1; end
    else ca++;
  endtask

  task automatic drive_b(input logic [7:0] px, input logic sof);
    @(posedge clk); #1;
    b_if.pix_in = px; b_if.pix_valid = 1'b1; b_if.pix_sof = sof;
    if (sof) begin rb = 0; cb = 0; end
    exp_q_b.push_back({(rb == 2 && cb == 2), px});
    if (cb == 2) begin cb = 0; rb = (rb == 2) ? 0 : rb + 1; end
    else cb++;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    a_if.pix_valid = 1'b0; a_if.pix_sof = 1'b0;
    b_if.pix_valid = 1'b0; b_if.pix_sof = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    idle();
    while ((exp_q_a.size() != 0 || exp_q_b.size() != 0) && t < 40) begin
      @(negedge clk);
      t++;
    end
    check_eq("drain_a", exp_q_a.size(), 0);
    check_eq("drain_b", exp_q_b.size(), 0);
  endtask

  always @(posedge clk) begin
    acc_a <= a_if.pix_valid;
    acc_b <= b_if.pix_valid;
  end

  initial begin : monitor
    logic [36:0] ea;
    logic [8:0]  eb;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_a = '0;
        last_b = '0;
      end else begin
        if (a_if.en_out) begin
          check_eq("a_en_after_accept", acc_a, 1);
          if (exp_q_a.size() == 0) check_eq("a_unexpected_en", 1, 0);
          else begin
            ea = exp_q_a.pop_front();
            check_eq("a_window", a_if.data2conv, ea[35:0]);
            check_eq("a_frame_done", a_if.frame_done, ea[36]);
            last_a = ea[35:0];
          end
          got_a++;
          if (a_if.frame_done) done_a++;
        end else begin
          check_eq("a_hold", a_if.data2conv, last_a);
          check_eq("a_done_idle", a_if.frame_done, 0);
        end
        if (b_if.en_out) begin
          check_eq("b_en_after_accept", acc_b, 1);
          if (exp_q_b.size() == 0) check_eq("b_unexpected_en", 1, 0);
          else begin
            eb = exp_q_b.pop_front();
            check_eq("b_window", b_if.data2conv, eb[7:0]);
            check_eq("b_frame_done", b_if.frame_done, eb[8]);
            last_b = eb[7:0];
          end
          got_b++;
          if (b_if.frame_done) done_b++;
        end else begin
          check_eq("b_hold", b_if.data2conv, last_b);
          check_eq("b_done_idle", b_if.frame_done, 0);
        end
      end
    end
  end

  initial begin
    int base, dbase;
    rst = 1'b1;
    a_if.pix_in = '0; a_if.pix_valid = 1'b0; a_if.pix_sof = 1'b0;
    b_if.pix_in = '0; b_if.pix_valid = 1'b0; b_if.pix_sof = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_a_en", a_if.en_out, 0);
    check_eq("rst_a_data", a_if.data2conv, 0);
    check_eq("rst_a_done", a_if.frame_done, 0);
    check_eq("rst_b_en", b_if.en_out, 0);
    check_eq("rst_b_data", b_if.data2conv, 0);
    @(posedge clk); #1 rst = 1'b0;

    // T1: single frame with no gaps
    base = got_a; dbase = done_a;
    for (int i = 0; i < 25; i++) drive_a(4'(i), i == 0);
    drain();
    check_eq("t1_count", got_a - base, 9);
    check_eq("t1_done", done_a - dbase, 1);

    // T2: random gaps
    base = got_a; dbase = done_a;
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(1, 0) == 1) repeat ($urandom_range(3, 1)) idle();
      drive_a(4'(i), i == 0);
    end
    drain();
    check_eq("t2_count", got_a - base, 9);
    check_eq("t2_done", done_a - dbase, 1);

    // T3: frame abandoned by pix_sof after one window, then a full frame
    base = got_a; dbase = done_a;
    for (int i = 0; i < 13; i++) drive_a(4'(i + 3), i == 0);
    for (int i = 0; i < 25; i++) drive_a(4'(i), i == 0);
    drain();
    check_eq("t3_count", got_a - base, 10);
    check_eq("t3_done", done_a - dbase, 1);

    // T4: reset mid-frame, then a full frame without pix_sof
    for (int i = 0; i < 14; i++) drive_a(4'(i + 5), i == 0);
    drain();
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check_eq("t4_rst_en", a_if.en_out, 0);
    check_eq("t4_rst_data", a_if.data2conv, 0);
    check_eq("t4_rst_done", a_if.frame_done, 0);
    @(posedge clk); #1 rst = 1'b0;
    ra = 0; ca = 0;
    base = got_a; dbase = done_a;
    for (int i = 0; i < 25; i++) drive_a(4'(i), 1'b0);
    drain();
    check_eq("t4_count", got_a - base, 9);
    check_eq("t4_done", done_a - dbase, 1);

    // T6: two back-to-back frames, pix_sof only on the first
    base = got_a; dbase = done_a;
    for (int i = 0; i < 50; i++) drive_a(4'(i % 25), i == 0);
    drain();
    check_eq("t6_count", got_a - base, 18);
    check_eq("t6_done", done_a - dbase, 2);

    // T5: K=1 passes each pixel through one cycle later
    base = got_b; dbase = done_b;
    for (int i = 0; i < 9; i++) begin
      if ($urandom_range(1, 0) == 1) idle();
      drive_b(8'($urandom_range(255, 0)), i == 0);
    end
    drain();
    check_eq("t5_count", got_b - base, 9);
    check_eq("t5_done", done_b - dbase, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
